// File: rtl/soc_ahb3_ext_responder.sv
// soc_ahb3_ext_responder: AHB3-Lite word memory slave with programmable wait states and OKAY/ERROR responses.
module soc_ahb3_ext_responder #(
    parameter int PLEN        = 32,
    parameter int XLEN        = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ahb3_hsel_i,
    input  logic [PLEN-1:0] ahb3_haddr_i,
    input  logic [XLEN-1:0] ahb3_hwdata_i,
    input  logic            ahb3_hwrite_i,
    input  logic [2:0]      ahb3_hsize_i,
    input  logic [2:0]      ahb3_hburst_i,
    input  logic [3:0]      ahb3_hprot_i,
    input  logic [1:0]      ahb3_htrans_i,
    input  logic            ahb3_hmastlock_i,
    input  logic            ahb3_hready_i,
    output logic            ahb3_hreadyout_o,
    output logic            ahb3_hresp_o,
    output logic [XLEN-1:0] ahb3_hrdata_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t          st, st_n;
    logic [3:0]      cnt, cnt_n;
    logic [AW+1:0]   a;
    logic            wr;
    logic [2:0]      sz;
    logic            acc, bad;
    logic [3:0]      be;
    logic [XLEN-1:0] mem [DEPTH];
    logic            unused;

    assign unused = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i, ahb3_haddr_i[PLEN-1:AW+2]};

    assign ahb3_hreadyout_o = (st != WAIT) && (st != ERR1);
    assign ahb3_hresp_o     = (st == ERR1) || (st == ERR2);
    assign ahb3_hrdata_o    = (st == DATA && !wr) ? mem[a[AW+1:2]] : '0;

    // Address-phase inputs only count while this slave is driving HREADY high
    assign acc = ahb3_hreadyout_o && ahb3_hsel_i && ahb3_hready_i && ahb3_htrans_i[1];
    assign bad = (ahb3_hsize_i > 3'd2) ||
                 (ahb3_hsize_i == 3'd1 && ahb3_haddr_i[0]) ||
                 (ahb3_hsize_i == 3'd2 && |ahb3_haddr_i[1:0]);

    always_comb begin
        st_n  = IDLE;
        cnt_n = cnt;
        if (acc) begin
            st_n  = bad ? ERR1 : (WAIT_STATES > 0 ? WAIT : DATA);
            cnt_n = 4'(WAIT_STATES);
        end else if (st == WAIT) begin
            st_n  = (cnt == 4'd1) ? DATA : WAIT;
            cnt_n = cnt - 4'd1;
        end else if (st == ERR1) begin
            st_n = ERR2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
            a   <= '0;
            wr  <= 1'b0;
            sz  <= 3'd0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
            if (acc) begin
                a  <= ahb3_haddr_i[AW+1:0];
                wr <= ahb3_hwrite_i;
                sz <= ahb3_hsize_i;
            end
        end
    end

    always_comb be = (sz == 3'd0) ? 4'b0001 << a[1:0] :
                     (sz == 3'd1) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    always_ff @(posedge clk) begin
        if (st == DATA && wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[a[AW+1:2]][8*i +: 8] <= ahb3_hwdata_i[8*i +: 8];
    end
endmodule

// File: tb/tb_soc_ahb3_ext_responder.sv
// tb_soc_ahb3_ext_responder: randomized pipelined AHB traffic on two responders (0 and 3 wait states) against a byte-array model.
module tb_soc_ahb3_ext_responder;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic        hsel [2];
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic        hwrite [2];
    logic [2:0]  hsize [2];
    logic [1:0]  htrans [2];
    logic        hreadyout [2];
    logic        hresp [2];
    logic [31:0] hrdata [2];

    soc_ahb3_ext_responder #(.WAIT_STATES(0)) d0 (
        .clk(clk), .rst(rst), .ahb3_hsel_i(hsel[0]), .ahb3_haddr_i(haddr[0]),
        .ahb3_hwdata_i(hwdata[0]), .ahb3_hwrite_i(hwrite[0]), .ahb3_hsize_i(hsize[0]),
        .ahb3_hburst_i(3'd0), .ahb3_hprot_i(4'd0), .ahb3_htrans_i(htrans[0]),
        .ahb3_hmastlock_i(1'b0), .ahb3_hready_i(hreadyout[0]), .ahb3_hreadyout_o(hreadyout[0]),
        .ahb3_hresp_o(hresp[0]), .ahb3_hrdata_o(hrdata[0]));

    soc_ahb3_ext_responder #(.WAIT_STATES(3)) d3 (
        .clk(clk), .rst(rst), .ahb3_hsel_i(hsel[1]), .ahb3_haddr_i(haddr[1]),
        .ahb3_hwdata_i(hwdata[1]), .ahb3_hwrite_i(hwrite[1]), .ahb3_hsize_i(hsize[1]),
        .ahb3_hburst_i(3'd0), .ahb3_hprot_i(4'd0), .ahb3_htrans_i(htrans[1]),
        .ahb3_hmastlock_i(1'b0), .ahb3_hready_i(hreadyout[1]), .ahb3_hreadyout_o(hreadyout[1]),
        .ahb3_hresp_o(hresp[1]), .ahb3_hrdata_o(hrdata[1]));

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
    } xf_t;

    int          total = 0;
    int          bad = 0;
    int          ws [2] = '{0, 3};
    logic [7:0]  mb [2][1024];
    xf_t         q [$];
    logic [31:0] got [$];
    int          lows [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic xf_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        xf_t x;
        x.sel = sel; x.tr = tr; x.wr = wr; x.sz = sz; x.a = a; x.d = d;
        return x;
    endfunction

    // 0 = no access, 1 = OKAY access, 2 = ERROR
    function automatic int kind(input xf_t x);
        if (!x.sel || !x.tr[1]) return 0;
        if (x.sz > 3'd2) return 2;
        if ((x.a % (32'd1 << x.sz)) != 0) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] mrd(input int k, input logic [31:0] a);
        int b = int'(a[9:0]) & ~3;
        return {mb[k][b+3], mb[k][b+2], mb[k][b+1], mb[k][b]};
    endfunction

    task automatic mwr(input int k, input xf_t x);
        int nb = 1 << x.sz;
        int b = int'(x.a[9:0]) & ~(nb - 1);
        for (int j = 0; j < nb; j++) mb[k][b+j] = x.d[8*((b+j)%4) +: 8];
    endtask

    task automatic drive_idle(input int k);
        hsel[k] = 0; htrans[k] = 2'd0; hwrite[k] = 0; hsize[k] = 3'd0; haddr[k] = 0; hwdata[k] = 0;
    endtask

    // Issues q pipelined on responder k; got/lows record each transfer's data phase.
    task automatic run(input int k);
        int n = q.size();
        int low, kd;
        xf_t cur, prv;
        bit have = 0;
        got.delete();
        lows.delete();
        for (int i = 0; i <= n; i++) begin
            cur = (i < n) ? q[i] : mk(0, 2'd0, 0, 3'd0, 0, 0);
            hsel[k] = cur.sel; htrans[k] = cur.tr; hwrite[k] = cur.wr;
            hsize[k] = cur.sz; haddr[k] = cur.a;
            hwdata[k] = have ? prv.d : $urandom;
            kd = have ? kind(prv) : 0;
            low = 0;
            @(negedge clk);
            while (hreadyout[k] == 0 && low < 40) begin
                low++;
                check("low_resp", 32'(hresp[k]), 32'(kd == 2));
                check("low_rdata", hrdata[k], 0);
                @(negedge clk);
            end
            if (have) begin
                check("latency", low, kd == 0 ? 0 : kd == 2 ? 1 : ws[k]);
                check("resp", 32'(hresp[k]), 32'(kd == 2));
                if (kd == 1 && prv.wr) mwr(k, prv);
                check("rdata", hrdata[k], (kd == 1 && !prv.wr) ? mrd(k, prv.a) : 0);
                got.push_back(hrdata[k]);
                lows.push_back(low);
            end
            @(posedge clk);
            #1;
            prv = cur;
            have = 1;
        end
        q.delete();
    endtask

    task automatic rand_traffic(input int k, input int n);
        logic [2:0] sz;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a = $urandom;
            if (sz <= 3'd2 && $urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 1);
            q.push_back(mk($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 1'($urandom),
                           sz, a, $urandom));
        end
        run(k);
    endtask

    logic [31:0] nd;
    int sum;

    initial begin
        for (int k = 0; k < 2; k++) drive_idle(k);
        #2;
        for (int k = 0; k < 2; k++) begin
            check("rst_rdy", 32'(hreadyout[k]), 1);
            check("rst_resp", 32'(hresp[k]), 0);
            check("rst_rdata", hrdata[k], 0);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 256; w++) q.push_back(mk(1, 2'd2, 1, 3'd2, 32'(w * 4), $urandom));
            run(k);
        end

        q.push_back(mk(1, 2'd2, 1, 3'd2, 32'h10, 32'hDEADBEEF));
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h10, 0));
        run(0);
        check("b2b_read", got[1], 32'hDEADBEEF);
        check("b2b_lat", lows[1], 0);

        q.push_back(mk(1, 2'd2, 1, 3'd2, 32'h10, 32'h11223344));
        q.push_back(mk(1, 2'd2, 1, 3'd0, 32'h13, 32'hAA000000));
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h10, 0));
        q.push_back(mk(1, 2'd2, 1, 3'd1, 32'h10, 32'h00005566));
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h10, 0));
        run(0);
        check("byte_wr", got[2], 32'hAA223344);
        check("half_wr", got[4], 32'hAA225566);

        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h02, 0));
        q.push_back(mk(1, 2'd2, 1, 3'd3, 32'h10, 32'h0));
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h10, 0));
        run(0);
        check("err_lat", lows[0], 1);
        check("err_size_lat", lows[1], 1);
        check("after_err", got[2], 32'hAA225566);

        q.push_back(mk(1, 2'd2, 1, 3'd2, 32'h400, 32'h0BADF00D));
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h000, 0));
        run(0);
        check("wrap", got[1], 32'h0BADF00D);

        for (int b = 0; b < 4; b++) q.push_back(mk(1, b == 0 ? 2'd2 : 2'd3, 0, 3'd2, 32'(b * 4), 0));
        run(1);
        sum = 0;
        for (int b = 0; b < 4; b++) sum += lows[b] + 1;
        check("burst_cycles", sum, 16);

        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h0, 0));
        q.push_back(mk(1, 2'd1, 0, 3'd2, 32'h4, 0));
        q.push_back(mk(1, 2'd3, 0, 3'd2, 32'h4, 0));
        q.push_back(mk(1, 2'd0, 0, 3'd2, 32'h8, 0));
        q.push_back(mk(1, 2'd3, 0, 3'd2, 32'h8, 0));
        run(1);
        check("busy_lat", lows[1], 0);
        check("idle_lat", lows[3], 0);
        check("seq_lat", lows[4], 3);

        nd = ~mrd(1, 32'h14);
        hsel[1] = 1; htrans[1] = 2'd2; hwrite[1] = 1; hsize[1] = 3'd2; haddr[1] = 32'h14;
        @(posedge clk);
        #1;
        drive_idle(1);
        hwdata[1] = nd;
        @(negedge clk);
        check("pre_rst_wait", 32'(hreadyout[1]), 0);
        #2 rst = 1;
        #1;
        check("arst_rdy", 32'(hreadyout[1]), 1);
        check("arst_resp", 32'(hresp[1]), 0);
        check("arst_rdata", hrdata[1], 0);
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_rdy", 32'(hreadyout[1]), 1);
            check("post_rst_rdata", hrdata[1], 0);
        end
        @(posedge clk);
        #1;
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h14, 0));
        run(1);
        check("rst_discard", 32'(got[0] != nd), 1);

        rand_traffic(0, 300);
        rand_traffic(1, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/soc_ahb3_ext_responder.md
# soc_ahb3_ext_responder

AMBA3 AHB-Lite slave that sits on the MPSoC external bus port and answers the transfers the system issues there. It is a word-organised local memory with a programmable number of wait states and OKAY/ERROR responses, so simulations can exercise the external port against a real responder instead of tying it off. It handles single and burst transfers one beat at a time, with byte, halfword and word writes.

## Interface

Parameters:
- PLEN, 32, address width.
- XLEN, 32, data width (fixed 32 in this revision).
- DEPTH, 256, memory size in 32-bit words; power of two, at least 2.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted before every OKAY data phase (0..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ahb3_hsel_i  in  1  slave select.
- ahb3_haddr_i  in  PLEN  address.
- ahb3_hwdata_i  in  XLEN  write data, valid in the data phase.
- ahb3_hwrite_i  in  1  1 = write, 0 = read.
- ahb3_hsize_i  in  3  transfer size.
- ahb3_hburst_i  in  3  ignored.
- ahb3_hprot_i  in  4  ignored.
- ahb3_htrans_i  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- ahb3_hmastlock_i  in  1  ignored.
- ahb3_hready_i  in  1  bus HREADY (previous transfer complete).
- ahb3_hreadyout_o  out  1  this slave's HREADY.
- ahb3_hresp_o  out  1  0 = OKAY, 1 = ERROR.
- ahb3_hrdata_o  out  XLEN  read data.

## Operation

- A transfer is accepted on a rising edge with hsel_i=1, hready_i=1 and htrans_i[1]=1. On acceptance the block latches haddr, hwrite and hsize.
- IDLE or BUSY transfers, or cycles with hsel_i=0, get a zero-wait OKAY and cause no access.
- The word index is haddr[log2(DEPTH)+1:2]. Higher address bits are ignored, so accesses wrap modulo DEPTH words.
- Error checks, evaluated at acceptance:
  - hsize greater than 2.
  - Halfword access with haddr[0]=1.
  - Word access with haddr[1:0] not equal to 0.
  - An erroring transfer never modifies memory.
- State machine:
  - IDLE: waiting for a transfer. On an accepted OK transfer, go to WAIT if WAIT_STATES>0, otherwise DATA. On an accepted erroring transfer, go to ERR1.
  - WAIT: hreadyout low. The counter is loaded with WAIT_STATES at acceptance and decrements each cycle. Go to DATA when the counter reaches 1.
  - DATA: hreadyout high, hresp 0.
    - Write: bytes are committed at the end of this cycle, using byte enables from the latched hsize and haddr[1:0] (byte = 1 lane, halfword = lanes 0-1 or 2-3, word = all 4).
    - Read: hrdata = mem[index], the full word regardless of hsize.
    - If a new transfer is accepted in the same edge, branch as from IDLE; otherwise return to IDLE.
  - ERR1: hreadyout 0, hresp 1. Always go to ERR2.
  - ERR2: hreadyout 1, hresp 1. Accept a new transfer as in DATA, otherwise go to IDLE.
- hrdata_o is 0 in every state except a read in DATA.
- Memory contents are not reset.

## Timing

- Reset values: hreadyout_o=1, hresp_o=0, hrdata_o=0, state IDLE, wait counter 0. Reset in the middle of a transfer abandons it; a pending write is discarded.
- OKAY latency: with the address phase in cycle N, the data phase completes in cycle N+1+WAIT_STATES.
- ERROR latency is always two cycles (ERR1, ERR2), independent of WAIT_STATES.
- While hreadyout_o=0, address-phase inputs are ignored. The master may change htrans during ERR1; that change has no effect.
- Back-to-back transfers: when a write data phase is followed immediately by a read of the same word, the read returns the new data, because the write commits on the edge that ends its data phase.
- Pipelined bursts (SEQ) sustain one beat per 1+WAIT_STATES cycles.

## Test plan

- Reset with rst=1 mid-run: hreadyout=1, hresp=0 and hrdata=0 immediately (asynchronous), and they stay so until the first accepted transfer.
- WAIT_STATES=0, NONSEQ word write 0xDEADBEEF to address 0x10, then word read of 0x10 back-to-back: the read data phase returns 0xDEADBEEF with hreadyout high in the cycle after the read address phase.
- Byte write 0xAA to address 0x13 over an existing word 0x11223344: a word read of 0x10 returns 0xAA223344. Halfword write 0x5566 to address 0x10: the read returns 0xAA225566.
- Errors from word read at 0x02 and from hsize=3: hreadyout/hresp = (0,1) then (1,1), and the memory word is unchanged. A NONSEQ transfer accepted in ERR2 completes OKAY normally.
- WAIT_STATES=3, 4-beat SEQ read burst from 0x00: each beat shows exactly 3 hreadyout-low cycles, then data; the burst takes 16 cycles total. IDLE and BUSY transfers interleaved in the burst get zero-wait OKAY.
- DEPTH=256, write to address 0x400: a read of address 0x000 returns the same value (wrap-around).
